// File: rtl/serial_borrow_subtractor.sv
// Digit-serial subtractor: diff = a - b - bin over WIDTH bits, DIGIT bits per clock.
// A registered borrow links successive digits; flags are captured with the last digit.
module serial_borrow_subtractor #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DIGIT = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_bin,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_diff,
  output logic             o_bout,
  output logic             o_zero,
  output logic             o_ovf
);

  localparam int unsigned NDIG = WIDTH / DIGIT;
  localparam int unsigned CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_a, r_b, r_diff;
  logic             r_borrow;
  logic [CW-1:0]    r_cnt;
  logic             r_a_msb, r_b_msb;
  logic             r_bout, r_zero, r_ovf;

  logic [DIGIT-1:0] w_d;
  logic             w_c;
  logic [WIDTH-1:0] w_diff_nxt;
  logic             w_last;
  logic             w_ovf;

  // One DIGIT-wide borrow ripple on the low bits of the shifting operands.
  always_comb begin
    w_c = r_borrow;
    w_d = '0;
    for (int i = 0; i < DIGIT; i++) begin
      w_d[i] = r_a[i] ^ r_b[i] ^ w_c;
      w_c    = (~r_a[i] & r_b[i]) | (~(r_a[i] ^ r_b[i]) & w_c);
    end
  end

  always_comb begin
    w_diff_nxt = r_diff;
    for (int k = 0; k < NDIG; k++) begin
      if (r_cnt == CW'(k)) w_diff_nxt[k*DIGIT +: DIGIT] = w_d;
    end
  end

  assign w_last = (r_cnt == CW'(NDIG - 1));
  assign w_ovf  = (r_a_msb != r_b_msb) && (w_diff_nxt[WIDTH-1] != r_a_msb);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= StIdle;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:  if (i_in_valid)  w_state_nxt = StRun;
      StRun:   if (w_last)      w_state_nxt = StDone;
      StDone:  if (i_out_ready) w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_diff   <= '0;
      r_borrow <= 1'b0;
      r_cnt    <= '0;
      r_a_msb  <= 1'b0;
      r_b_msb  <= 1'b0;
      r_bout   <= 1'b0;
      r_zero   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (i_in_valid) begin
            r_a      <= i_a;
            r_b      <= i_b;
            r_borrow <= i_bin;
            r_cnt    <= '0;
            r_a_msb  <= i_a[WIDTH-1];
            r_b_msb  <= i_b[WIDTH-1];
          end
        end
        StRun: begin
          r_a      <= r_a >> DIGIT;
          r_b      <= r_b >> DIGIT;
          r_borrow <= w_c;
          r_diff   <= w_diff_nxt;
          r_cnt    <= r_cnt + 1'b1;
          if (w_last) begin
            r_bout <= w_c;
            r_zero <= (w_diff_nxt == '0);
            r_ovf  <= w_ovf;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_in_ready  = (r_state == StIdle);
  assign o_out_valid = (r_state == StDone);
  assign o_diff      = r_diff;
  assign o_bout      = r_bout;
  assign o_zero      = r_zero;
  assign o_ovf       = r_ovf;

endmodule

// File: tb/tb_serial_borrow_subtractor.sv
// Scoreboard bench: drivers push expected results, monitors pop them on out_valid & out_ready.
// Main instance W=16/D=4 uses hand-computed vectors; three more instances sweep W/D.
module tb_serial_borrow_subtractor;

  typedef struct {
    logic [31:0] diff;
    logic        bout;
    logic        zero;
    logic        ovf;
    int          acc;
  } exp_t;

  logic clk, rst_n;
  int   cyc;
  int   n_checks, n_errors;
  bit   sweep_go;

  logic        in_valid, in_ready, bin, out_valid, out_ready, bout, zero, ovf;
  logic [15:0] a, b, diff;
  exp_t        q_main[$];

  serial_borrow_subtractor #(.WIDTH(16), .DIGIT(4)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_a(a), .i_b(b), .i_bin(bin), .o_out_valid(out_valid), .i_out_ready(out_ready),
    .o_diff(diff), .o_bout(bout), .o_zero(zero), .o_ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic send(input logic [15:0] ta, input logic [15:0] tb, input logic tbin,
                      input bit push, input logic [15:0] ed, input logic eb,
                      input logic ez, input logic eo);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("main accept wait", in_ready, 1);
    a = ta;
    b = tb;
    bin = tbin;
    in_valid = 1'b1;
    if (push) q_main.push_back('{diff: 32'(ed), bout: eb, zero: ez, ovf: eo, acc: cyc});
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q_main.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("main drain", q_main.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // Main monitor
  initial begin
    bit   prev_v;
    int   rise;
    exp_t e;
    prev_v = 1'b0;
    rise   = 0;
    forever begin
      @(negedge clk);
      if (out_valid && !prev_v) rise = cyc;
      prev_v = out_valid;
      if (out_valid && out_ready) begin
        if (q_main.size() == 0) begin
          check("main spurious out_valid", out_valid, 0);
        end else begin
          e = q_main.pop_front();
          check("main diff", diff, e.diff[15:0]);
          check("main bout", bout, e.bout);
          check("main zero", zero, e.zero);
          check("main ovf", ovf, e.ovf);
          check("main latency", rise - e.acc - 1, 4);
        end
      end
    end
  end

  for (genvar g = 0; g < 3; g++) begin : g_sw
    localparam int unsigned W = (g == 0) ? 8 : (g == 1) ? 16 : 32;
    localparam int unsigned D = (g == 0) ? 1 : (g == 1) ? 16 : 8;

    logic         iv, ir, ov, sbin, sbo, sz, so;
    logic [W-1:0] sa, sb, sd;
    exp_t         q[$];
    bit           done;

    serial_borrow_subtractor #(.WIDTH(W), .DIGIT(D)) u_sw (
      .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(iv), .o_in_ready(ir),
      .i_a(sa), .i_b(sb), .i_bin(sbin), .o_out_valid(ov), .i_out_ready(1'b1),
      .o_diff(sd), .o_bout(sbo), .o_zero(sz), .o_ovf(so)
    );

    initial begin
      logic [W-1:0] va, vb;
      logic         vbin;
      logic [W:0]   full;
      int           n;
      iv   = 1'b0;
      sa   = '0;
      sb   = '0;
      sbin = 1'b0;
      done = 1'b0;
      wait (sweep_go);
      for (int i = 0; i < 20; i++) begin
        va   = W'($urandom);
        vb   = W'($urandom);
        vbin = 1'($urandom);
        if (i == 0) begin
          vb   = va;
          vbin = 1'b1;
        end else if (i == 1) begin
          va   = '0;
          vb   = W'(1);
          vbin = 1'b0;
        end
        full = {1'b0, va} - {1'b0, vb} - {{W{1'b0}}, vbin};
        @(negedge clk);
        n = 0;
        while (!ir && n < 100) begin
          @(negedge clk);
          n++;
        end
        check("sweep accept wait", ir, 1);
        sa   = va;
        sb   = vb;
        sbin = vbin;
        iv   = 1'b1;
        q.push_back('{diff: 32'(full[W-1:0]), bout: full[W], zero: (full[W-1:0] == '0),
                      ovf: (va[W-1] != vb[W-1]) && (full[W-1] != va[W-1]), acc: cyc});
        @(posedge clk);
        #1 iv = 1'b0;
      end
      n = 0;
      while (q.size() != 0 && n < 200) begin
        @(negedge clk);
        n++;
      end
      check("sweep drain", q.size(), 0);
      done = 1'b1;
    end

    initial begin
      bit   pv;
      int   rise;
      exp_t e;
      pv   = 1'b0;
      rise = 0;
      forever begin
        @(negedge clk);
        if (ov && !pv) rise = cyc;
        pv = ov;
        if (ov) begin
          if (q.size() == 0) begin
            check("sweep spurious out_valid", ov, 0);
          end else begin
            e = q.pop_front();
            check("sweep diff", sd, e.diff[W-1:0]);
            check("sweep bout", sbo, e.bout);
            check("sweep zero", sz, e.zero);
            check("sweep ovf", so, e.ovf);
            check("sweep latency", rise - e.acc - 1, W / D);
          end
        end
      end
    end
  end

  initial begin
    int n;
    n_checks  = 0;
    n_errors  = 0;
    sweep_go  = 1'b0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    bin       = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset in_ready", in_ready, 1);
    check("reset out_valid", out_valid, 0);
    check("reset diff", diff, 0);
    check("reset flags", {bout, zero, ovf}, 0);
    rst_n = 1'b1;

    send(16'h1234, 16'h0234, 1'b0, 1, 16'h1000, 1'b0, 1'b0, 1'b0);
    send(16'h0000, 16'h0001, 1'b0, 1, 16'hFFFF, 1'b1, 1'b0, 1'b0);
    send(16'h8000, 16'h0001, 1'b0, 1, 16'h7FFF, 1'b0, 1'b0, 1'b1);
    send(16'h5A5A, 16'h5A59, 1'b1, 1, 16'h0000, 1'b0, 1'b1, 1'b0);
    send(16'h7777, 16'h7777, 1'b1, 1, 16'hFFFF, 1'b1, 1'b0, 1'b0);
    send(16'h7FFF, 16'hFFFF, 1'b0, 1, 16'h8000, 1'b1, 1'b0, 1'b1);
    drain();

    // Backpressure, with in_valid pulses during RUN that must be ignored
    out_ready = 1'b0;
    send(16'h9ABC, 16'h1234, 1'b0, 1, 16'h8888, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b1;
    a = 16'hFFFF;
    b = 16'h0000;
    repeat (2) @(posedge clk);
    #1 in_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("bp out_valid", out_valid, 1);
    for (int k = 0; k < 5; k++) begin
      check("bp diff held", diff, 16'h8888);
      check("bp flags held", {bout, zero, ovf}, 0);
      check("bp in_ready low", in_ready, 0);
      @(negedge clk);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    check("bp in_ready after release", in_ready, 1);
    check("bp out_valid after release", out_valid, 0);
    drain();

    // Reset during the second RUN cycle aborts the op
    send(16'h1111, 16'h0001, 1'b0, 0, 16'h0000, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort diff", diff, 0);
    check("abort flags", {bout, zero, ovf}, 0);
    check("abort out_valid", out_valid, 0);
    check("abort in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("abort no result", out_valid, 0);
    send(16'h0003, 16'h0005, 1'b0, 1, 16'hFFFE, 1'b1, 1'b0, 1'b0);
    drain();

    sweep_go = 1'b1;
    n = 0;
    while (!(g_sw[0].done && g_sw[1].done && g_sw[2].done) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check("sweep complete", {g_sw[0].done, g_sw[1].done, g_sw[2].done}, 3'b111);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
